// File: rtl/sar_search_12_pkg.sv
// Shared types and encodings for the successive-approximation search controller.
// Verdict codes follow the comparator's {L,E,G} output ordering.
package sar_search_12_pkg;

  localparam int unsigned SAR_WIDTH = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } sar_state_t;

  localparam logic [2:0] VERDICT_L = 3'b100;
  localparam logic [2:0] VERDICT_E = 3'b010;
  localparam logic [2:0] VERDICT_G = 3'b001;

endpackage

// File: rtl/sar_search_12.sv
// Successive-approximation search: drives trial onto a comparator's B operand
// and recovers its A operand MSB first from the E/G/L verdicts.
module sar_search_12
  import sar_search_12_pkg::*;
#(
  parameter int unsigned WIDTH  = SAR_WIDTH,
  parameter int unsigned SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_e,
  input  logic             cmp_g,
  input  logic             cmp_l,
  output logic [WIDTH-1:0] trial,
  output logic             cmp_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(WIDTH - 1);
  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : '0;
  localparam sar_state_t S_NEXT_BIT = (SETTLE > 0) ? S_WAIT : S_EVAL;
  localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  sar_state_t       r_state;
  sar_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_trial;
  logic [WIDTH-1:0] w_trial_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW-1:0]  w_idx_nxt;
  logic [3:0]       r_settle;
  logic [3:0]       w_settle_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_verdict;
  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_bit_lo;
  logic [WIDTH-1:0] w_decided;

  assign w_verdict = {cmp_l, cmp_e, cmp_g};
  assign w_bit     = ONE << r_idx;
  assign w_bit_lo  = w_bit >> 1;
  // L means the trial overshot A, so the bit under test is dropped.
  assign w_decided = (w_verdict == VERDICT_L) ? (r_trial & ~w_bit) : r_trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_trial  <= '0;
      r_result <= '0;
      r_idx    <= IDX_TOP;
      r_settle <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_trial  <= w_trial_nxt;
      r_result <= w_result_nxt;
      r_idx    <= w_idx_nxt;
      r_settle <= w_settle_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_EVAL);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_trial_nxt  = r_trial;
    w_result_nxt = r_result;
    w_idx_nxt    = r_idx;
    w_settle_nxt = r_settle;
    w_err_nxt    = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_NEXT_BIT;
          w_trial_nxt  = TRIAL_MSB;
          w_idx_nxt    = IDX_TOP;
          w_settle_nxt = '0;
          w_err_nxt    = 1'b0;
        end
      end
      S_WAIT: begin
        if (r_settle == SETTLE_LAST) begin
          w_settle_nxt = '0;
          w_state_nxt  = S_EVAL;
        end else begin
          w_settle_nxt = r_settle + 4'd1;
        end
      end
      S_EVAL: begin
        case (w_verdict)
          VERDICT_L, VERDICT_G: begin
            if (r_idx == '0) begin
              w_trial_nxt  = w_decided;
              w_result_nxt = w_decided;
              w_state_nxt  = S_DONE;
            end else begin
              w_trial_nxt = w_decided | w_bit_lo;
              w_idx_nxt   = r_idx - 1'b1;
              w_state_nxt = S_NEXT_BIT;
            end
          end
          VERDICT_E: begin
            w_result_nxt = r_trial;
            w_state_nxt  = S_DONE;
          end
          default: begin
            w_result_nxt = '0;
            w_err_nxt    = 1'b1;
            w_state_nxt  = S_DONE;
          end
        endcase
      end
      S_DONE: begin
        w_idx_nxt   = IDX_TOP;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign trial   = r_trial;
  assign cmp_cin = 1'b0;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign err     = r_err;

endmodule

// File: tb/tb_sar_search_12.sv
// Bench for sar_search_12: two instances (SETTLE=0 and SETTLE=3) each answered by
// a behavioural comparator on a bench-driven A operand.
module tb_sar_search_12;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start0 = 1'b0, start3 = 1'b0;
  logic [W-1:0] a0 = '0, a3 = '0;
  logic         inj0 = 1'b0, inj3 = 1'b0;

  logic [W-1:0] trial0, trial3, result0, result3;
  logic         busy0, busy3, done0, done3, err0, err3, cin0, cin3;
  logic         e0, g0, l0, e3, g3, l3;

  // Comparator responders; inj forces the illegal verdict {l,e,g}=011.
  assign e0 = inj0 ? 1'b1 : (a0 == trial0);
  assign g0 = inj0 ? 1'b1 : (a0 >  trial0);
  assign l0 = inj0 ? 1'b0 : (a0 <  trial0);
  assign e3 = inj3 ? 1'b1 : (a3 == trial3);
  assign g3 = inj3 ? 1'b1 : (a3 >  trial3);
  assign l3 = inj3 ? 1'b0 : (a3 <  trial3);

  sar_search_12 #(.WIDTH(W), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .cmp_e(e0), .cmp_g(g0), .cmp_l(l0),
    .trial(trial0), .cmp_cin(cin0), .busy(busy0), .done(done0),
    .result(result0), .err(err0)
  );

  sar_search_12 #(.WIDTH(W), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .cmp_e(e3), .cmp_g(g3), .cmp_l(l3),
    .trial(trial3), .cmp_cin(cin3), .busy(busy3), .done(done3),
    .result(result3), .err(err3)
  );

  int total = 0;
  int bad = 0;
  int sel = 0;

  logic [W-1:0] o_trial, o_result;
  logic         o_busy, o_done, o_err, o_cin;
  assign o_trial  = (sel != 0) ? trial3  : trial0;
  assign o_result = (sel != 0) ? result3 : result0;
  assign o_busy   = (sel != 0) ? busy3   : busy0;
  assign o_done   = (sel != 0) ? done3   : done0;
  assign o_err    = (sel != 0) ? err3    : err0;
  assign o_cin    = (sel != 0) ? cin3    : cin0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start3 = v; else start0 = v;
  endtask

  task automatic set_inj(input logic v);
    if (sel != 0) inj3 = v; else inj0 = v;
  endtask

  // Evaluations needed: search stops once the trial (A's upper bits plus the bit
  // under test) equals A, i.e. at A's lowest set bit; A=0 never matches.
  function automatic int ref_evals(input logic [W-1:0] a);
    if (a == '0) return W;
    for (int i = 0; i < W; i++) if (a[i]) return W - i;
    return W;
  endfunction

  // Trial presented while bit i is under test: A's bits above i, then a 1 at i.
  function automatic logic [W-1:0] ref_trial(input logic [W-1:0] a, input int i);
    int m;
    m = (1 << (i + 1)) - 1;
    return W'((int'(a) & ~m) | (1 << i));
  endfunction

  // inj: 1-based evaluation that sees the illegal verdict (0 = none).
  // noise: random start pulses while busy/done. hold: start held for a back-to-back search.
  task automatic run(input int s, input logic [W-1:0] a, input int inj,
                     input bit noise, input bit hold);
    int settle, k, d, first_done, second_done, ndone, last;
    sel = s;
    settle = (s != 0) ? 3 : 0;
    k = (inj > 0) ? inj : ref_evals(a);
    d = (settle + 1) * k + 1;
    first_done = 0;
    second_done = 0;
    ndone = 0;
    last = hold ? 2 * d + 4 : d + 3;
    if (s != 0) a3 = a; else a0 = a;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    if (!hold) set_start(1'b0);
    for (int n = 1; n <= last; n++) begin
      if (n <= d + 1) check("busy", {31'd0, o_busy}, {31'd0, (n < d)});
      set_inj((inj > 0) && (n == (settle + 1) * inj));
      if ((n % (settle + 1) == 0) && (n / (settle + 1) <= k) && (n < d))
        check("trial", {20'd0, o_trial}, {20'd0, ref_trial(a, W - n / (settle + 1))});
      if (o_done) begin
        ndone++;
        if (first_done == 0) first_done = n;
        else if (second_done == 0) second_done = n;
      end
      if (n == d || (hold && n == 2 * d + 1)) begin
        check("result", {20'd0, o_result}, (inj > 0) ? 32'd0 : {20'd0, a});
        check("err", {31'd0, o_err}, (inj > 0) ? 32'd1 : 32'd0);
      end
      if (hold && n == d + 2) begin
        check("hold_busy", {31'd0, o_busy}, 32'd1);
        check("hold_trial", {20'd0, o_trial}, 32'h800);
        set_start(1'b0);
      end
      if (noise && !hold) set_start((n <= d) ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge clk);
    end
    set_inj(1'b0);
    set_start(1'b0);
    check("done_cycle", first_done, d);
    if (hold) check("done2_cycle", second_done, 2 * d + 1);
    else check("done_count", ndone, 1);
  endtask

  task automatic reset_mid(input logic [W-1:0] a);
    int ndone;
    sel = 0;
    a0 = a;
    ndone = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_trial", {20'd0, o_trial}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_result", {20'd0, o_result}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (o_done) ndone++;
      @(negedge clk);
    end
    check("rst_no_done", ndone, 0);
    run(0, a, 0, 0, 0);
  endtask

  initial begin
    logic [W-1:0] ra;
    repeat (2) @(negedge clk);
    sel = 0;
    check("reset_trial", {20'd0, o_trial}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    check("reset_result", {20'd0, o_result}, 32'd0);
    check("reset_err", {31'd0, o_err}, 32'd0);
    check("cin", {31'd0, o_cin}, 32'd0);
    rst_n = 1'b1;

    run(0, 12'hA5C, 0, 0, 0);
    run(0, 12'h800, 0, 0, 0);
    run(0, 12'h000, 0, 0, 0);
    run(0, 12'hFFF, 0, 0, 0);
    run(1, 12'h123, 0, 0, 0);
    run(0, 12'h5A1, 2, 0, 0);
    run(0, 12'h5A1, 0, 0, 0);
    reset_mid(12'h9E7);
    run(0, 12'h6B0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, 4095));
      run(0, ra, 0, 1, 0);
    end
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom_range(0, 4095));
      run(1, ra, 0, 1, 0);
    end
    sel = 1;
    check("cin3", {31'd0, o_cin}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
